// File: rtl/bypass_sel_stage_pkg.sv
// Shared definitions for the bypass select stage: select-width helper,
// error-counter width and the stage occupancy encoding.
package bypass_sel_stage_pkg;

   localparam int ERRCNT_W = 16;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } stage_state_e;

   // Select must encode 0 (constant zero) plus 1..n, hence n+1 codes.
   function automatic int sel_w_f(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/bypass_sel_stage_sel_mux_n.sv
// Index-based N:1 selector. Code 0 and codes above NUM_IN yield zero;
// codes above NUM_IN also raise oor_o. Each slice is AND-masked by its own
// decode so unselected slices (even X) never reach the output.
module sel_mux_n
   import bypass_sel_stage_pkg::*;
#(
   parameter  int WIDTH  = 32,
   parameter  int NUM_IN = 8,
   localparam int SEL_W  = sel_w_f(NUM_IN)
) (
   input  logic [SEL_W-1:0]        select_i,
   input  logic [NUM_IN*WIDTH-1:0] in_bus_i,
   output logic [WIDTH-1:0]        data_o,
   output logic                    oor_o
);

   // AND-OR selection: no priority chain, one-hot decode per slice.
   always_comb begin
      data_o = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         data_o = data_o |
                  (in_bus_i[k*WIDTH +: WIDTH] & {WIDTH{select_i == SEL_W'(k + 1)}});
      end
   end

   // Out-of-range detection for codes beyond the last input.
   always_comb begin
      oor_o = (select_i > SEL_W'(NUM_IN));
   end

endmodule

// File: rtl/bypass_sel_stage.sv
// Registered bypass select stage: one-cycle latency, stall/flush control,
// sticky select-error flag. Define BYPASS_SEL_ERRCNT_EN to add a saturating
// 16-bit count of out-of-range accepts on port err_cnt.
module bypass_sel_stage
   import bypass_sel_stage_pkg::*;
#(
   parameter  int WIDTH  = 32,
   parameter  int NUM_IN = 8,
   localparam int SEL_W  = sel_w_f(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    stall,
   input  logic                    flush,
   input  logic                    valid_in,
   input  logic [SEL_W-1:0]        select,
   input  logic [NUM_IN*WIDTH-1:0] in_bus,
   output logic [WIDTH-1:0]        out,
   output logic                    valid_out,
   output logic                    sel_err
`ifdef BYPASS_SEL_ERRCNT_EN
   ,
   output logic [ERRCNT_W-1:0]     err_cnt
`endif
);

   stage_state_e     state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             sel_err_q, sel_err_d;
   logic [WIDTH-1:0] mux_data;
   logic             mux_oor;
   logic             accept;

   sel_mux_n #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN)
   ) u_mux (
      .select_i (select),
      .in_bus_i (in_bus),
      .data_o   (mux_data),
      .oor_o    (mux_oor)
   );

   assign accept = valid_in & ~stall & ~flush;

   // Next state: flush beats stall, stall freezes everything, otherwise
   // valid_in decides whether the stage fills or drains.
   always_comb begin
      state_d   = state_q;
      out_d     = out_q;
      sel_err_d = sel_err_q;
      if (flush) begin
         state_d = EMPTY;
         out_d   = '0;
      end else if (!stall) begin
         if (valid_in) begin
            state_d   = FULL;
            out_d     = mux_data;
            sel_err_d = sel_err_q | mux_oor;
         end else begin
            state_d = EMPTY;
         end
      end
   end

   // Stage registers with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= EMPTY;
         out_q     <= '0;
         sel_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_q     <= out_d;
         sel_err_q <= sel_err_d;
      end
   end

   assign out       = out_q;
   assign valid_out = (state_q == FULL);
   assign sel_err   = sel_err_q;

`ifdef BYPASS_SEL_ERRCNT_EN
   logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

   // Saturating count of out-of-range accepts; stall/flush block accept.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (accept && mux_oor && (err_cnt_q != {ERRCNT_W{1'b1}}))
         err_cnt_d = err_cnt_q + ERRCNT_W'(1);
   end

   // Counter register, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) err_cnt_q <= '0;
      else       err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`else
   logic unused_accept;
   assign unused_accept = accept;
`endif

endmodule

// File: doc/bypass_sel_stage.md
BYPASS_SEL_STAGE -- requirements
Module: bypass_sel_stage

Interface
REQ-001 Parameter WIDTH, default 32, data width of each input and of the output.
REQ-002 Parameter NUM_IN, default 8, number of data inputs, legal range 2..15.
REQ-003 Localparam SEL_W = clog2(NUM_IN+1), select width; not overridable.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 stall  input  1  hold all registered state for this cycle.
REQ-007 flush  input  1  invalidate the stage.
REQ-008 valid_in  input  1  the select and data on this cycle are meaningful.
REQ-009 select  input  SEL_W  encoded choice; 1..NUM_IN picks IN1..IN<NUM_IN>; 0 picks constant zero.
REQ-010 in_bus  input  NUM_IN*WIDTH  concatenated inputs; IN1 occupies bits [WIDTH-1:0], and IN<k> occupies slice k-1.
REQ-011 out  output  WIDTH  registered selected value.
REQ-012 valid_out  output  1  out holds a valid result.
REQ-013 sel_err  output  1  sticky flag: an out-of-range select was accepted.

Function
REQ-014 Accept condition: valid_in=1, stall=0, flush=0; on accept, out SHALL load the selected value on the next edge, and valid_out SHALL become 1.
REQ-015 Latency SHALL be exactly one cycle from accept to out/valid_out.
REQ-016 select=0 on accept SHALL load out=0, with valid_out=1 and no error.
REQ-017 select>NUM_IN on accept SHALL load out=0, set valid_out=1 and set sel_err=1.
REQ-018 valid_in=0 with stall=0 and flush=0 SHALL clear valid_out, and out SHALL retain its previous value.
REQ-019 stall=1 with flush=0 SHALL hold out, valid_out and sel_err unchanged, regardless of valid_in and select.
REQ-020 flush=1 SHALL clear valid_out and SHALL load out=0 on the next edge.
REQ-021 flush SHALL take priority over stall.
REQ-022 sel_err SHALL remain 1 until reset and SHALL NOT be cleared by flush.
REQ-023 Selection SHALL be purely index-based, with no priority among inputs and no X-propagation from unselected slices.
REQ-024 Stage state machine: EMPTY (valid_out=0) and FULL (valid_out=1).
REQ-025 EMPTY to FULL on accept; FULL to FULL on accept; FULL to EMPTY on flush or on valid_in=0 without stall; stall holds the current state.

Reset
REQ-026 reset=1 SHALL immediately force out=0, valid_out=0, sel_err=0 (and err_cnt=0 when REQ-028 applies), independent of clk.
REQ-027 Reset asserted mid-operation, including during stall, SHALL abandon the pending result; the first accept after deassertion SHALL behave as from EMPTY.

Configuration
REQ-028 Macro BYPASS_SEL_ERRCNT_EN defined: the block SHALL add output err_cnt (16 bits), which increments on every accept with select>NUM_IN, saturates at 0xFFFF, holds on stall, and is cleared only by reset.
REQ-029 Macro BYPASS_SEL_ERRCNT_EN undefined: the block SHALL have no err_cnt port and no counter logic; all other behaviour SHALL be identical.

Structure
REQ-030 A shared package SHALL hold the SEL_W computation function, the ERRCNT_W=16 constant and the stage-state encoding (EMPTY/FULL).
REQ-031 Combinational selection SHALL live in one sub-module, sel_mux_n (parameters WIDTH and NUM_IN, inputs select and in_bus, outputs the selected value and an out-of-range flag).
REQ-032 The top level SHALL contain only the registers, the stall/flush control and the optional counter.

Verification
REQ-033 Reset, then valid_in=1, select=3, IN3=0xDEADBEEF -> after one edge, out=0xDEADBEEF and valid_out=1.
REQ-034 Accept select=5 (IN5=0x11), then stall=1 for 3 cycles while select=2 -> out remains 0x11 and valid_out remains 1 throughout.
REQ-035 stall=1 and flush=1 together while FULL -> next edge: out=0, valid_out=0.
REQ-036 NUM_IN=8, accept select=12 -> out=0, valid_out=1, sel_err=1; a subsequent flush leaves sel_err=1.
REQ-037 BYPASS_SEL_ERRCNT_EN defined, 70000 accepts with select=15 -> err_cnt=0xFFFF; reset -> err_cnt=0.
REQ-038 Reset asserted between clock edges while FULL -> out=0 and valid_out=0 before the next edge; a select=1 accept after release -> out=IN1.
